// File: rtl/bcd2bin_fsm.sv
// Bit-serial reverse double-dabble: packed BCD in, unsigned binary out.
// One shift or one nibble-correct step per clock; 30 cycles per conversion.
module bcd2bin_fsm #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk100Mhz,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SHIFT     = 2'd1;
  localparam logic [1:0] S_CHECK_SUB = 2'd2;
  localparam logic [1:0] S_FINISH    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] r_bcd_q, r_bcd_d;
  logic [BIN_W-1:0]    w_bin_q, w_bin_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DIGITS-1:0]   bad_nib;
  logic [4*DIGITS-1:0] r_bcd_fix;

  // Per-nibble input validity and the independent "-3 if >= 8" correction.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign bad_nib[gi] = (bcd[4*gi +: 4] > 4'd9);
      assign r_bcd_fix[4*gi +: 4] = (r_bcd_q[4*gi +: 4] >= 4'd8) ?
                                    (r_bcd_q[4*gi +: 4] - 4'd3) : r_bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_bcd_d = r_bcd_q;
    w_bin_d = w_bin_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        cnt_d  = '0;
        if (start) begin
          if (|bad_nib) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            r_bcd_d = bcd;
            w_bin_d = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        {r_bcd_d, w_bin_d} = {1'b0, r_bcd_q, w_bin_q[BIN_W-1:1]};
        cnt_d   = cnt_q + CNT_ONE;
        state_d = S_CHECK_SUB;
      end
      S_CHECK_SUB: begin
        r_bcd_d = r_bcd_fix;
        state_d = (cnt_q < CNT_LAST) ? S_SHIFT : S_FINISH;
      end
      default: begin
        bin_d   = w_bin_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100Mhz) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_bcd_q <= '0;
      w_bin_q <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_bcd_q <= r_bcd_d;
      w_bin_q <= w_bin_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
